// File: rtl/mfda_ctrl_pkg.sv
// Shared types for the reagent mixer sequencer: FSM state encoding, default counter width,
// and the phase-skip helper that picks the next non-empty phase.
// No ports (package).
package mfda_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DOSE_A,
    DOSE_B,
    MIX,
    SETTLE,
    READ,
    FINISH
  } seq_state_e;

  // Returns the first phase after 'cur' whose duration is non-zero (nz = {settle, mix, b, a}).
  // Zero-length phases are skipped entirely; READ is always the fallback.
  function automatic seq_state_e next_phase(input seq_state_e cur, input logic [3:0] nz);
    seq_state_e nxt;
    nxt = READ;
    if (nz[3] && (cur inside {SCAN, DOSE_A, DOSE_B, MIX})) nxt = SETTLE;
    if (nz[2] && (cur inside {SCAN, DOSE_A, DOSE_B}))      nxt = MIX;
    if (nz[1] && (cur inside {SCAN, DOSE_A}))              nxt = DOSE_B;
    if (nz[0] && (cur == SCAN))                            nxt = DOSE_A;
    return nxt;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Purpose: loadable down-counter timing one sequencer phase; expire marks the phase's last cycle.
// Latency: value loaded on the edge where i_load is high; o_expire is combinational from the count.
// Backpressure: none. Ports: clk, rst_n, i_load, i_value (duration), o_expire.
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Counts down and parks at zero; never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A count of 1 is the last cycle of the phase; a count of 0 (loaded with 0) expires at once.
  assign o_expire = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/mix_channel_sequencer.sv
// Purpose: walks enabled mixer channels in ascending order: valve A, valve B, pump, settle, detector read.
// Latency: SCAN costs 1 cycle per channel; phases chain back-to-back; done pulses 2 cycles after start with no channels.
// Backpressure: READ holds det_req until det_ack; abort returns to IDLE on the next cycle without done.
// Ports: clk/rst_n, start/abort, ch_enable + four durations (latched at start), valve_a/valve_b/mix_pump drives,
//        det_req/det_ch/det_ack/det_flag detector handshake, result flags, busy, done.
module mix_channel_sequencer
  import mfda_ctrl_pkg::*;
#(
  parameter int NUM_CH = 12,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [CNT_W-1:0]          dose_a_cyc,
  input  logic [CNT_W-1:0]          dose_b_cyc,
  input  logic [CNT_W-1:0]          mix_cyc,
  input  logic [CNT_W-1:0]          settle_cyc,
  output logic [NUM_CH-1:0]         valve_a,
  output logic [NUM_CH-1:0]         valve_b,
  output logic [NUM_CH-1:0]         mix_pump,
  output logic                      det_req,
  output logic [$clog2(NUM_CH)-1:0] det_ch,
  input  logic                      det_ack,
  input  logic                      det_flag,
  output logic [NUM_CH-1:0]         result,
  output logic                      busy,
  output logic                      done
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = CH_W + 1;  // pointer must be able to reach NUM_CH (past the last channel)

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_result;
  logic [CNT_W-1:0]  r_dur_a;
  logic [CNT_W-1:0]  r_dur_b;
  logic [CNT_W-1:0]  r_dur_m;
  logic [CNT_W-1:0]  r_dur_s;
  logic [CH_W-1:0]   r_ch;
  logic [PTR_W-1:0]  r_ptr;
  logic [3:0]        w_nz;
  logic              w_found;
  logic [CH_W-1:0]   w_sel;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_expire;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_take_start;
  logic              w_take_ack;

  assign w_nz = {(r_dur_s != '0), (r_dur_m != '0), (r_dur_b != '0), (r_dur_a != '0)};

  // Lowest enabled channel at or above the pointer.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_found && r_en[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_sel   = CH_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:                        if (start) w_state_nxt = SCAN;
      SCAN:                        w_state_nxt = w_found ? next_phase(SCAN, w_nz) : FINISH;
      DOSE_A, DOSE_B, MIX, SETTLE: if (w_expire) w_state_nxt = next_phase(r_state, w_nz);
      READ:                        if (det_ack) w_state_nxt = SCAN;
      FINISH:                      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // The single timer is reloaded on every state change; only timed phases care about its value.
  always_comb begin
    w_load_val = '0;
    case (w_state_nxt)
      DOSE_A:  w_load_val = r_dur_a;
      DOSE_B:  w_load_val = r_dur_b;
      MIX:     w_load_val = r_dur_m;
      SETTLE:  w_load_val = r_dur_s;
      default: w_load_val = '0;
    endcase
  end

  assign w_load = (w_state_nxt != r_state);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .o_expire (w_expire)
  );

  assign w_take_start = (r_state == IDLE) && start && !abort;
  assign w_take_ack   = (r_state == READ) && det_ack && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_en     <= '0;
      r_dur_a  <= '0;
      r_dur_b  <= '0;
      r_dur_m  <= '0;
      r_dur_s  <= '0;
      r_ch     <= '0;
      r_ptr    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_start) begin
        r_en     <= ch_enable;
        r_dur_a  <= dose_a_cyc;
        r_dur_b  <= dose_b_cyc;
        r_dur_m  <= mix_cyc;
        r_dur_s  <= settle_cyc;
        r_ptr    <= '0;
        r_result <= '0;
      end
      if ((r_state == SCAN) && w_found) begin
        r_ch <= w_sel;
      end
      if (w_take_ack) begin
        r_result[r_ch] <= det_flag;
        r_ptr          <= PTR_W'(r_ch) + PTR_W'(1);
      end
    end
  end

  // Drives decode straight from the state register so an async reset drops them immediately.
  assign w_onehot = NUM_CH'(1) << r_ch;
  assign valve_a  = (r_state == DOSE_A) ? w_onehot : '0;
  assign valve_b  = (r_state == DOSE_B) ? w_onehot : '0;
  assign mix_pump = (r_state == MIX)    ? w_onehot : '0;
  assign det_req  = (r_state == READ);
  assign det_ch   = r_ch;
  assign result   = r_result;
  assign busy     = (r_state != IDLE) && (r_state != FINISH);
  assign done     = (r_state == FINISH);

endmodule

// File: tb/tb_mix_channel_sequencer.sv
module tb_mix_channel_sequencer;

  localparam int NUM_CH = 12;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] ch_enable;
  logic [CNT_W-1:0]  dose_a_cyc;
  logic [CNT_W-1:0]  dose_b_cyc;
  logic [CNT_W-1:0]  mix_cyc;
  logic [CNT_W-1:0]  settle_cyc;
  logic [NUM_CH-1:0] valve_a;
  logic [NUM_CH-1:0] valve_b;
  logic [NUM_CH-1:0] mix_pump;
  logic              det_req;
  logic [3:0]        det_ch;
  logic              det_ack;
  logic              det_flag;
  logic [NUM_CH-1:0] result;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  mix_channel_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .ch_enable  (ch_enable),
    .dose_a_cyc (dose_a_cyc),
    .dose_b_cyc (dose_b_cyc),
    .mix_cyc    (mix_cyc),
    .settle_cyc (settle_cyc),
    .valve_a    (valve_a),
    .valve_b    (valve_b),
    .mix_pump   (mix_pump),
    .det_req    (det_req),
    .det_ch     (det_ch),
    .det_ack    (det_ack),
    .det_flag   (det_flag),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- detector responder ----------------
  int  ack_dly = 0;
  bit  stray   = 0;
  int  rsp_wait = 0;
  logic fq[$];

  initial begin
    det_ack  = 1'b0;
    det_flag = 1'b0;
    forever begin
      @(posedge clk); #2;
      det_ack  = 1'b0;
      det_flag = 1'b0;
      if (det_req) begin
        if (rsp_wait >= ack_dly) begin
          det_ack  = 1'b1;
          det_flag = (fq.size() > 0) ? fq.pop_front() : 1'b0;
          rsp_wait = 0;
        end else begin
          rsp_wait++;
        end
      end else begin
        rsp_wait = 0;
        if (stray) begin
          det_ack  = 1'b1;
          det_flag = 1'b1;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Expected outputs for the cycle following each rising edge, produced by walking the run as a program.
  logic [NUM_CH-1:0] m_va = '0, m_vb = '0, m_mp = '0, m_result = '0;
  logic              m_req = 0, m_busy = 0, m_done = 0;
  int                m_ch = 0;
  bit                m_kill = 0;
  logic [NUM_CH-1:0] m_en;
  logic [CNT_W-1:0]  m_dur[4];

  task automatic m_edge();
    @(posedge clk);
    if (!rst_n) begin
      m_kill   = 1;
      m_result = '0;
    end else if (abort) begin
      m_kill = 1;
    end
  endtask

  // p: 0 valve A, 1 valve B, 2 pump, anything else no drive
  task automatic m_drive(input int p, input int c);
    m_va = (p == 0) ? (NUM_CH'(1) << c) : '0;
    m_vb = (p == 1) ? (NUM_CH'(1) << c) : '0;
    m_mp = (p == 2) ? (NUM_CH'(1) << c) : '0;
  endtask

  initial begin
    forever begin
      m_drive(4, 0);
      m_req  = 0;
      m_busy = 0;
      m_done = 0;
      m_kill = 0;
      forever begin
        @(posedge clk);
        if (!rst_n) m_result = '0;
        else if (start && !abort) break;
      end
      m_en = ch_enable;
      m_dur[0] = dose_a_cyc;
      m_dur[1] = dose_b_cyc;
      m_dur[2] = mix_cyc;
      m_dur[3] = settle_cyc;
      m_result = '0;
      m_busy   = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_kill) break;
        if (!m_en[c]) continue;
        for (int p = 0; p < 4; p++) begin
          for (int k = 0; k < int'(m_dur[p]); k++) begin
            if (m_kill) break;
            m_edge();
            if (!m_kill) m_drive(p, c);
          end
        end
        if (m_kill) break;
        m_edge();
        if (m_kill) break;
        m_drive(4, c);
        m_req = 1;
        m_ch  = c;
        forever begin
          m_edge();
          if (m_kill) break;
          if (det_ack) begin
            m_result[c] = det_flag;
            m_req = 0;
            break;
          end
        end
      end
      if (!m_kill) begin
        m_edge();
        if (!m_kill) begin
          m_busy = 0;
          m_done = 1;
          m_edge();
        end
      end
    end
  end

  // ---------------- compare + activity monitor ----------------
  int n_va = 0, n_vb = 0, n_mp = 0, n_req = 0, n_done = 0;
  int order_q[$];
  logic [NUM_CH-1:0] prev_va = '0;

  function automatic int idx_of(input logic [NUM_CH-1:0] v);
    int r;
    r = -1;
    for (int i = NUM_CH - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("valve_a", 32'(valve_a), 32'(m_va));
        chk("valve_b", 32'(valve_b), 32'(m_vb));
        chk("mix_pump", 32'(mix_pump), 32'(m_mp));
        chk("det_req", 32'(det_req), 32'(m_req));
        if (m_req) chk("det_ch", 32'(det_ch), 32'(m_ch));
        chk("result", 32'(result), 32'(m_result));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
      end
      if (valve_a != '0) n_va++;
      if (valve_b != '0) n_vb++;
      if (mix_pump != '0) n_mp++;
      if (det_req) n_req++;
      if (done) n_done++;
      if (valve_a != '0 && prev_va == '0) order_q.push_back(idx_of(valve_a));
      prev_va = valve_a;
    end
  end

  // ---------------- stimulus helpers ----------------
  int b_va, b_vb, b_mp, b_req, b_done, b_ord;

  task automatic base();
    b_va = n_va; b_vb = n_vb; b_mp = n_mp; b_req = n_req; b_done = n_done; b_ord = order_q.size();
  endtask

  task automatic go(input logic [NUM_CH-1:0] en, input int a, input int b, input int m, input int s);
    @(posedge clk); #2;
    ch_enable  = en;
    dose_a_cyc = CNT_W'(a);
    dose_b_cyc = CNT_W'(b);
    mix_cyc    = CNT_W'(m);
    settle_cyc = CNT_W'(s);
    start      = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    ch_enable = '0; dose_a_cyc = '0; dose_b_cyc = '0; mix_cyc = '0; settle_cyc = '0;
    repeat (3) @(negedge clk);
    chk("rst_valve_a", 32'(valve_a), 0);
    chk("rst_valve_b", 32'(valve_b), 0);
    chk("rst_mix_pump", 32'(mix_pump), 0);
    chk("rst_det_req", 32'(det_req), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    chk_en = 1;

    // 1: single channel, 3/2/4/1, ack two cycles after request
    fq = {1'b1}; ack_dly = 2; base();
    go(12'h001, 3, 2, 4, 1);
    wait_done("t1", 200);
    chk("t1_va_cycles", n_va - b_va, 3);
    chk("t1_vb_cycles", n_vb - b_vb, 2);
    chk("t1_mp_cycles", n_mp - b_mp, 4);
    chk("t1_req_cycles", n_req - b_req, 3);
    chk("t1_done_pulses", n_done - b_done, 1);
    chk("t1_result", 32'(result), 32'h001);
    chk("t1_model_result", 32'(m_result), 32'h001);

    // 2: channels 0, 5, 11 with single-cycle phases, no settle, same-cycle ack
    fq = {1'b1, 1'b0, 1'b1}; ack_dly = 0; base();
    go(12'h821, 1, 1, 1, 0);
    wait_done("t2", 200);
    chk("t2_order_count", order_q.size() - b_ord, 3);
    if (order_q.size() - b_ord == 3) begin
      chk("t2_order0", order_q[b_ord], 0);
      chk("t2_order1", order_q[b_ord + 1], 5);
      chk("t2_order2", order_q[b_ord + 2], 11);
    end
    chk("t2_req_cycles", n_req - b_req, 3);
    chk("t2_result", 32'(result), 32'h801);
    chk("t2_model_result", 32'(m_result), 32'h801);

    // 3: zero B and mix durations, stray acks outside READ
    fq = {1'b0}; ack_dly = 1; stray = 1; base();
    go(12'h004, 2, 0, 0, 3);
    wait_done("t3", 200);
    stray = 0;
    chk("t3_va_cycles", n_va - b_va, 2);
    chk("t3_vb_cycles", n_vb - b_vb, 0);
    chk("t3_mp_cycles", n_mp - b_mp, 0);
    chk("t3_result", 32'(result), 32'h000);

    // 4: empty mask
    base();
    go(12'h000, 3, 3, 3, 3);
    @(negedge clk);
    chk("t4_busy_c1", 32'(busy), 1);
    chk("t4_done_c1", 32'(done), 0);
    @(negedge clk);
    chk("t4_done_c2", 32'(done), 1);
    chk("t4_busy_c2", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t4_va_cycles", n_va - b_va, 0);
    chk("t4_result", 32'(result), 32'h000);

    // abort and start together in IDLE: nothing starts
    @(posedge clk); #2;
    ch_enable = 12'h001; start = 1'b1; abort = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", 32'(busy), 0);

    // 5: abort during mix on channel 3
    fq = {1'b1}; ack_dly = 1; base();
    go(12'h00A, 2, 2, 5, 1);
    n = 0;
    while (!mix_pump[3] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_mix3", 32'(mix_pump[3]), 1);
    @(posedge clk); #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_drives_low", 32'(valve_a | valve_b | mix_pump), 0);
    chk("t5_req_low", 32'(det_req), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_result_kept", 32'(result), 32'h002);
    repeat (5) @(negedge clk);
    chk("t5_no_done", n_done - b_done, 0);
    fq = {1'b1}; base();
    go(12'h008, 1, 1, 1, 1);
    wait_done("t5b", 200);
    chk("t5b_done_pulses", n_done - b_done, 1);
    chk("t5b_result", 32'(result), 32'h008);

    // 6: async reset in the middle of valve A
    chk_en = 0;
    fq = {}; ack_dly = 0;
    go(12'h001, 10, 1, 1, 1);
    n = 0;
    while (!valve_a[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_dose_a", 32'(valve_a[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valve_a_async", 32'(valve_a), 0);
    chk("t6_busy_async", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_drives", 32'(valve_a | valve_b | mix_pump), 0);
    chk("t6_post_req", 32'(det_req), 0);
    chk("t6_post_result", 32'(result), 0);
    chk("t6_post_busy", 32'(busy), 0);
    chk("t6_post_done", 32'(done), 0);
    chk_en = 1;

    // start re-pulsed while busy is ignored, latched config untouched
    fq = {1'b1}; ack_dly = 1; base();
    go(12'h001, 2, 2, 2, 2);
    n = 0;
    while (!valve_b[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t7_reached_dose_b", 32'(valve_b[0]), 1);
    @(posedge clk); #2;
    ch_enable = 12'hFFF; dose_a_cyc = 16'd9; dose_b_cyc = 16'd9; mix_cyc = 16'd9; settle_cyc = 16'd9;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("t7", 200);
    chk("t7_va_cycles", n_va - b_va, 2);
    chk("t7_mp_cycles", n_mp - b_mp, 2);
    chk("t7_done_pulses", n_done - b_done, 1);
    chk("t7_result", 32'(result), 32'h001);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
